adc_acq_scheduler: RTL and testbench

- Sequences conversion acquisitions on the ADC SPI manager by issuing single-cycle conversion triggers at a programmable period, for a programmable sample count or continuously.
- Sits between the AXI-Lite configuration registers and the manager's trigger input.
- Watches the manager's status word and output-stream handshake. A trigger is never issued while the manager is busy or out of conversion mode.
- Reports progress, completion and skipped (overrun) ticks.

---
 rtl/adc_pkg.sv | 33 +++
 rtl/adc_tick_gen.sv | 38 +++
 rtl/adc_acq_scheduler.sv | 178 +++++++++++++++++
 tb/tb_adc_acq_scheduler.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// ============================================================================
// Module  : adc_pkg
// Brief   : Shared status-word layout, device modes and scheduler states.
// Revision: 1.0
// ============================================================================
`default_nettype none

package adc_pkg;

  localparam int STATUS_ACTIVE    = 0;
  localparam int STATUS_REG_AVAIL = 1;
  localparam int STATUS_MODE_LSB  = 2;

  localparam logic [1:0] MODE_CONVERSION = 2'b00;
  localparam logic [1:0] MODE_REG_ONCE   = 2'b01;
  localparam logic [1:0] MODE_REG        = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } sched_state_t;

  // Manager may accept a trigger only when idle, not mid register access,
  // and in conversion mode.
  function automatic logic adc_ready(input logic [31:0] status);
    return !status[STATUS_ACTIVE] && !status[STATUS_REG_AVAIL] &&
           (status[STATUS_MODE_LSB +: 2] == MODE_CONVERSION);
  endfunction

endpackage

`default_nettype wire

// File: rtl/adc_tick_gen.sv
// ============================================================================
// Module  : adc_tick_gen
// Brief   : Free-running period counter; flags a tick whenever the count is 0.
// Revision: 1.0
// ============================================================================
`default_nettype none

module adc_tick_gen #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [CNT_WIDTH-1:0] period,
  output logic                 tick
);

  localparam logic [CNT_WIDTH-1:0] c_one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [CNT_WIDTH-1:0] r_count;
  logic [CNT_WIDTH-1:0] w_last;

  assign w_last = period - c_one;

  always_ff @(posedge aclk) begin
    if (areset || clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= (r_count == w_last) ? '0 : r_count + c_one;
    end
  end

  assign tick = enable && (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/adc_acq_scheduler.sv
// ============================================================================
// Module  : adc_acq_scheduler
// Brief   : Issues periodic conversion triggers to the ADC SPI manager and
//           tracks issued, received and skipped samples per acquisition.
// Revision: 1.0
// ============================================================================
`default_nettype none

module adc_acq_scheduler
  import adc_pkg::*;
#(
  parameter int CNT_WIDTH  = 32,
  parameter int MIN_PERIOD = 16,
  parameter int SKIP_WIDTH = 16
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [CNT_WIDTH-1:0]  cfg_period,
  input  logic [CNT_WIDTH-1:0]  cfg_count,
  input  logic                  cfg_start,
  input  logic                  cfg_stop,
  input  logic [31:0]           adc_status,
  input  logic                  sample_tvalid,
  input  logic                  sample_tready,
  output logic                  trigger,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_error,
  output logic                  overrun,
  output logic [CNT_WIDTH-1:0]  issued_count,
  output logic [CNT_WIDTH-1:0]  received_count,
  output logic [SKIP_WIDTH-1:0] skipped_count
);

  localparam logic [CNT_WIDTH-1:0]  c_min_period = CNT_WIDTH'(MIN_PERIOD);
  localparam logic [CNT_WIDTH-1:0]  c_cnt_one    = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [SKIP_WIDTH-1:0] c_skip_one   = {{(SKIP_WIDTH-1){1'b0}}, 1'b1};

  sched_state_t r_state, w_next_state;

  logic [CNT_WIDTH-1:0]  r_period;
  logic [CNT_WIDTH-1:0]  r_count;
  logic [CNT_WIDTH-1:0]  r_issued;
  logic [CNT_WIDTH-1:0]  r_received;
  logic [SKIP_WIDTH-1:0] r_skipped;
  logic                  r_trigger;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_cfg_error;
  logic                  r_overrun;

  logic                 w_tick;
  logic                 w_ready;
  logic                 w_hs;
  logic                 w_start_ok;
  logic                 w_start_err;
  logic                 w_fire;
  logic                 w_skip;
  logic                 w_done;
  logic [CNT_WIDTH-1:0] w_issued_inc;
  logic                 w_unused_status;

  assign w_unused_status = ^adc_status[31:4];
  assign w_ready         = adc_ready(adc_status);
  assign w_hs            = sample_tvalid && sample_tready;
  assign w_issued_inc    = r_issued + c_cnt_one;

  adc_tick_gen #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_tick_gen (
    .aclk   (aclk),
    .areset (areset),
    .clear  (w_start_ok),
    .enable (r_state == ST_RUN),
    .period (r_period),
    .tick   (w_tick)
  );

  always_comb begin
    w_next_state = r_state;
    w_start_ok   = 1'b0;
    w_start_err  = 1'b0;
    w_fire       = 1'b0;
    w_skip       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cfg_start && !cfg_stop) begin
          if (cfg_period >= c_min_period) begin
            w_start_ok   = 1'b1;
            w_next_state = ST_RUN;
          end else begin
            w_start_err  = 1'b1;
          end
        end
      end
      ST_RUN: begin
        // A stop landing on a tick suppresses that tick entirely.
        if (cfg_stop) begin
          w_next_state = ST_DRAIN;
        end else if (w_tick) begin
          if (w_ready) begin
            w_fire = 1'b1;
            if ((r_count != '0) && (w_issued_inc == r_count)) begin
              w_next_state = ST_DRAIN;
            end
          end else begin
            w_skip = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (r_received == r_issued) begin
          w_done       = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state     <= ST_IDLE;
      r_period    <= '0;
      r_count     <= '0;
      r_issued    <= '0;
      r_received  <= '0;
      r_skipped   <= '0;
      r_trigger   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cfg_error <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_trigger   <= w_fire;
      r_busy      <= (w_next_state != ST_IDLE);
      r_done      <= w_done;
      r_cfg_error <= w_start_err;
      if (w_start_ok) begin
        r_period   <= cfg_period;
        r_count    <= cfg_count;
        r_issued   <= '0;
        r_received <= '0;
        r_skipped  <= '0;
        r_overrun  <= 1'b0;
      end else begin
        if (w_fire) begin
          r_issued <= w_issued_inc;
        end
        if (w_skip) begin
          r_overrun <= 1'b1;
          if (r_skipped != {SKIP_WIDTH{1'b1}}) begin
            r_skipped <= r_skipped + c_skip_one;
          end
        end
        if ((r_state != ST_IDLE) && w_hs) begin
          r_received <= r_received + c_cnt_one;
        end
      end
    end
  end

  assign trigger        = r_trigger;
  assign busy           = r_busy;
  assign done           = r_done;
  assign cfg_error      = r_cfg_error;
  assign overrun        = r_overrun;
  assign issued_count   = r_issued;
  assign received_count = r_received;
  assign skipped_count  = r_skipped;

endmodule

`default_nettype wire

// File: tb/tb_adc_acq_scheduler.sv
// ============================================================================
// Module  : tb_adc_acq_scheduler
// Brief   : Self-checking bench: directed scenarios plus random traffic
//           compared every cycle against an elapsed-time behavioural model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_adc_acq_scheduler;

  localparam int CW   = 32;
  localparam int SW   = 4;
  localparam int MINP = 16;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic [CW-1:0] cfg_period = '0;
  logic [CW-1:0] cfg_count = '0;
  logic          cfg_start = 1'b0;
  logic          cfg_stop = 1'b0;
  logic [31:0]   adc_status = '0;
  logic          sample_tvalid = 1'b0;
  logic          sample_tready = 1'b0;
  logic          trigger, busy, done, cfg_error, overrun;
  logic [CW-1:0] issued_count, received_count;
  logic [SW-1:0] skipped_count;

  int n_pass  = 0;
  int n_total = 0;
  bit cmp_en  = 1'b0;

  always #5 aclk = ~aclk;

  adc_acq_scheduler #(
    .CNT_WIDTH  (CW),
    .MIN_PERIOD (MINP),
    .SKIP_WIDTH (SW)
  ) dut (
    .aclk           (aclk),
    .areset         (areset),
    .cfg_period     (cfg_period),
    .cfg_count      (cfg_count),
    .cfg_start      (cfg_start),
    .cfg_stop       (cfg_stop),
    .adc_status     (adc_status),
    .sample_tvalid  (sample_tvalid),
    .sample_tready  (sample_tready),
    .trigger        (trigger),
    .busy           (busy),
    .done           (done),
    .cfg_error      (cfg_error),
    .overrun        (overrun),
    .issued_count   (issued_count),
    .received_count (received_count),
    .skipped_count  (skipped_count)
  );

  // Model: mode 0 idle, 1 run, 2 drain; ticks fall where elapsed % period == 0.
  typedef struct packed {
    logic [1:0]    mode;
    logic [31:0]   elapsed;
    logic [CW-1:0] period;
    logic [CW-1:0] count;
    logic [CW-1:0] issued;
    logic [CW-1:0] received;
    logic [SW-1:0] skipped;
    logic          overrun;
    logic          trigger;
    logic          done;
    logic          err;
  } model_t;

  model_t m;

  function automatic model_t model_next(model_t c);
    model_t n = c;
    bit hs, ready, tick;
    n.trigger = 1'b0;
    n.done    = 1'b0;
    n.err     = 1'b0;
    if (areset) return '0;
    hs    = sample_tvalid && sample_tready;
    ready = (adc_status[3:0] == 4'b0000);
    case (c.mode)
      2'd0: if (cfg_start && !cfg_stop) begin
        if (cfg_period >= MINP) begin
          n.mode = 2'd1; n.period = cfg_period; n.count = cfg_count;
          n.issued = '0; n.received = '0; n.skipped = '0; n.overrun = 1'b0;
          n.elapsed = '0;
        end else begin
          n.err = 1'b1;
        end
      end
      2'd1: begin
        tick = ((c.elapsed % c.period) == 0);
        n.elapsed = c.elapsed + 1;
        if (hs) n.received = c.received + 1;
        if (cfg_stop) n.mode = 2'd2;
        else if (tick) begin
          if (ready) begin
            n.trigger = 1'b1;
            n.issued  = c.issued + 1;
            if (c.count != 0 && n.issued == c.count) n.mode = 2'd2;
          end else begin
            n.overrun = 1'b1;
            if (c.skipped != {SW{1'b1}}) n.skipped = c.skipped + 1;
          end
        end
      end
      default: begin
        if (c.received == c.issued) begin n.done = 1'b1; n.mode = 2'd0; end
        if (hs) n.received = c.received + 1;
      end
    endcase
    return n;
  endfunction

  always @(posedge aclk) m <= model_next(m);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge aclk) begin
    if (cmp_en) begin
      chk("trigger",   trigger,        m.trigger);
      chk("busy",      busy,           m.mode != 2'd0);
      chk("done",      done,           m.done);
      chk("cfg_error", cfg_error,      m.err);
      chk("overrun",   overrun,        m.overrun);
      chk("issued",    issued_count,   m.issued);
      chk("received",  received_count, m.received);
      chk("skipped",   skipped_count,  m.skipped);
    end
  end

  // Leaves the bench at the negedge just after the start edge ("rel 0").
  task automatic start_acq(input int period, input int count);
    @(negedge aclk);
    cfg_period = period; cfg_count = count; cfg_start = 1'b1; cfg_stop = 1'b0;
    @(negedge aclk);
    cfg_start = 1'b0;
  endtask

  task automatic drain_idle();
    @(negedge aclk);
    cfg_stop = 1'b1; cfg_start = 1'b0; adc_status = '0;
    sample_tvalid = 1'b0; sample_tready = 1'b0;
    @(negedge aclk);
    cfg_stop = 1'b0;
    for (int k = 0; k < 500; k++) begin
      if (!busy && m.mode == 2'd0) break;
      sample_tvalid = (m.received != m.issued);
      sample_tready = sample_tvalid;
      @(negedge aclk);
    end
    sample_tvalid = 1'b0; sample_tready = 1'b0;
    chk("drain_to_idle", busy, 1'b0);
  endtask

  int trig_rel[4];
  int n_trig, done_rel, n_evt;
  int due[$];
  int r;
  logic [31:0] tmp;

  initial begin
    repeat (3) @(negedge aclk);
    chk("reset_busy", busy, 1'b0);
    chk("reset_issued", issued_count, 0);
    areset = 1'b0;
    cmp_en = 1'b1;

    // Period 20, count 4, each trigger answered 10 cycles later.
    start_acq(20, 4);
    n_trig = 0; done_rel = -1;
    for (int rel = 1; rel < 100; rel++) begin
      @(negedge aclk);
      if (trigger) begin
        if (n_trig < 4) trig_rel[n_trig] = rel;
        n_trig++;
        due.push_back(rel + 10);
      end
      if (done && done_rel < 0) done_rel = rel;
      sample_tvalid = 1'b0; sample_tready = 1'b0;
      if (due.size() > 0 && due[0] == rel + 1) begin
        sample_tvalid = 1'b1; sample_tready = 1'b1;
        void'(due.pop_front());
      end
    end
    chk("t1_trig_count", n_trig, 4);
    for (int i = 0; i < 4; i++) chk("t1_trig_cycle", trig_rel[i], 1 + 20 * i);
    chk("t1_done_cycle", done_rel, 72);
    chk("t1_issued", issued_count, 4);
    chk("t1_received", received_count, 4);
    chk("t1_overrun", overrun, 1'b0);
    chk("t1_busy", busy, 1'b0);

    // Period below minimum is rejected.
    start_acq(10, 0);
    chk("t2_cfg_error", cfg_error, 1'b1);
    chk("t2_busy", busy, 1'b0);
    n_evt = 0;
    repeat (30) begin
      @(negedge aclk);
      n_evt += int'(trigger) + int'(cfg_error) + int'(busy);
    end
    chk("t2_quiet", n_evt, 0);

    // Stop coincident with the second tick; start in DRAIN ignored.
    start_acq(16, 0);
    for (int rel = 1; rel <= 20; rel++) begin
      @(negedge aclk);
      cfg_stop = 1'b0; cfg_start = 1'b0;
      sample_tvalid = 1'b0; sample_tready = 1'b0;
      if (rel == 1)  chk("t3_first_trig", trigger, 1'b1);
      if (rel == 16) cfg_stop = 1'b1;
      if (rel == 17) begin
        chk("t3_stop_no_trig", trigger, 1'b0);
        chk("t3_drain_busy", busy, 1'b1);
        chk("t3_issued", issued_count, 1);
        cfg_start = 1'b1; cfg_period = 20;
      end
      if (rel == 18) begin
        chk("t3_start_ignored", busy, 1'b1);
        sample_tvalid = 1'b1; sample_tready = 1'b1;
      end
      if (rel == 20) begin
        chk("t3_done", done, 1'b1);
        chk("t3_busy_low", busy, 1'b0);
      end
    end

    // Reset the cycle after a trigger.
    start_acq(16, 0);
    @(negedge aclk);
    chk("t4_trig", trigger, 1'b1);
    areset = 1'b1;
    @(negedge aclk);
    areset = 1'b0;
    chk("t4_trig_low", trigger, 1'b0);
    chk("t4_busy_low", busy, 1'b0);
    chk("t4_issued", issued_count, 0);
    n_evt = 0;
    repeat (5) begin @(negedge aclk); n_evt += int'(done); end
    chk("t4_no_done", n_evt, 0);

    // Register mode across a tick skips it; next tick triggers again.
    start_acq(16, 0);
    for (int rel = 1; rel <= 33; rel++) begin
      @(negedge aclk);
      adc_status = (rel == 16) ? 32'h0000_000C : 32'h0;
      if (rel == 17) begin
        chk("t5_skip_no_trig", trigger, 1'b0);
        chk("t5_skipped", skipped_count, 1);
        chk("t5_overrun", overrun, 1'b1);
      end
      if (rel == 33) chk("t5_resume", trigger, 1'b1);
    end
    drain_idle();

    // Saturation of the skipped counter; empty DRAIN completes at once.
    start_acq(16, 0);
    adc_status = 32'h1;
    repeat (20 * 16) @(negedge aclk);
    chk("t6_skip_sat", skipped_count, {SW{1'b1}});
    chk("t6_issued", issued_count, 0);
    drain_idle();

    // Random traffic, checked by the per-cycle compare process.
    for (int c = 0; c < 8000; c++) begin
      @(negedge aclk);
      r = $urandom_range(0, 199);
      cfg_start = (r < 6) || (r == 10);
      cfg_stop  = (r >= 8);
      cfg_stop  = (r >= 8 && r <= 10);
      cfg_period = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 15) : $urandom_range(16, 40);
      cfg_count  = $urandom_range(0, 6);
      tmp = $urandom;
      adc_status = (tmp & 32'hFFFF_FFF0) |
                   (($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 15)) : 32'h0);
      sample_tvalid = 1'($urandom_range(0, 1));
      if (m.mode == 2'd0) sample_tready = 1'($urandom_range(0, 1));
      else sample_tready = (m.received < m.issued) && ($urandom_range(0, 2) == 0);
      areset = ($urandom_range(0, 1999) == 0);
    end
    areset = 1'b0;
    drain_idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
